// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_MASK_W = DEF_WIDTH / 8;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IFU,
    OWN_LSU
  } owner_t;

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-input round-robin picker; priority flips to the loser on each accepted grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_lsu,
  input  logic req_ifu,
  input  logic grant_accept,
  output logic pick_lsu,
  output logic pick_ifu
);

  logic prio_lsu_q;

  // Priority register: LSU favoured out of reset, then favour whoever did not win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_lsu_q <= 1'b1;
    end else if (grant_accept) begin
      prio_lsu_q <= pick_ifu;
    end
  end

  // Winner selection: a lone requester wins, a tie goes to the favoured side.
  always_comb begin
    pick_lsu = req_lsu && (!req_ifu || prio_lsu_q);
    pick_ifu = req_ifu && (!req_lsu || !prio_lsu_q);
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares one data-memory port between IFU reads and LSU loads/stores,
// one transaction at a time, with a watchdog abort on hung responses.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MASK_W  = WIDTH / 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req,
  input  logic [WIDTH-1:0]  ifu_addr,
  output logic              ifu_gnt,
  output logic              ifu_rvalid,
  output logic [WIDTH-1:0]  ifu_rdata,
  input  logic              lsu_req,
  input  logic              lsu_we,
  input  logic [WIDTH-1:0]  lsu_addr,
  input  logic [WIDTH-1:0]  lsu_wdata,
  input  logic [MASK_W-1:0] lsu_mask,
  output logic              lsu_gnt,
  output logic              lsu_rvalid,
  output logic [WIDTH-1:0]  lsu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic [MASK_W-1:0] mem_mask,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              timeout
);

  localparam int             WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  state_t          state_q, state_d;
  owner_t          owner_q, owner_d;
  logic [WD_W-1:0] wd_q;
  logic            out_en_q;
  logic            pick_lsu, pick_ifu;
  logic            accept;
  logic [WIDTH-1:0] resp_data;

  rr_arb2 u_rr (
    .clk          (clk),
    .rst          (rst),
    .req_lsu      (lsu_req),
    .req_ifu      (ifu_req),
    .grant_accept (accept),
    .pick_lsu     (pick_lsu),
    .pick_ifu     (pick_ifu)
  );

  // State, owner and the post-reset output enable (keeps outputs quiet for one cycle after reset).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= OWN_NONE;
      out_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      out_en_q <= 1'b1;
    end
  end

  // Watchdog counter: cleared on grant, counts every BUSY cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else if (accept) begin
      wd_q <= '0;
    end else if (state_q == BUSY) begin
      wd_q <= wd_q + WD_W'(1);
    end
  end

  // Next-state and all outputs: request/grant in IDLE, response or abort in BUSY.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    accept     = 1'b0;
    resp_data  = '0;
    ifu_gnt    = 1'b0;
    ifu_rvalid = 1'b0;
    ifu_rdata  = '0;
    lsu_gnt    = 1'b0;
    lsu_rvalid = 1'b0;
    lsu_rdata  = '0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_mask   = '0;
    timeout    = 1'b0;
    case (state_q)
      IDLE: begin
        if (out_en_q && (pick_lsu || pick_ifu)) begin
          mem_req = 1'b1;
          if (pick_lsu) begin
            mem_we    = lsu_we;
            mem_addr  = lsu_addr;
            mem_wdata = lsu_wdata;
            mem_mask  = lsu_mask;
          end else begin
            mem_addr  = ifu_addr;
          end
          if (mem_ready) begin
            accept  = 1'b1;
            ifu_gnt = pick_ifu;
            lsu_gnt = pick_lsu;
            owner_d = pick_lsu ? OWN_LSU : OWN_IFU;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        // A real response in the expiry cycle takes precedence over the abort.
        if (mem_rvalid || (wd_q == WD_LAST)) begin
          resp_data = mem_rvalid ? mem_rdata : '0;
          timeout   = !mem_rvalid;
          if (owner_q == OWN_IFU) begin
            ifu_rvalid = 1'b1;
            ifu_rdata  = resp_data;
          end else if (owner_q == OWN_LSU) begin
            lsu_rvalid = 1'b1;
            lsu_rdata  = resp_data;
          end
          state_d = IDLE;
          owner_d = OWN_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter against a cycle-level reference model.
module tb_dmem_port_arbiter;

  localparam int W  = 32;
  localparam int MW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ifu_req, lsu_req, lsu_we, mem_ready, mem_rvalid;
  logic [W-1:0]  ifu_addr, lsu_addr, lsu_wdata, mem_rdata;
  logic [MW-1:0] lsu_mask;
  logic          ifu_gnt, ifu_rvalid, lsu_gnt, lsu_rvalid;
  logic [W-1:0]  ifu_rdata, lsu_rdata;
  logic          mem_req, mem_we, timeout;
  logic [W-1:0]  mem_addr, mem_wdata;
  logic [MW-1:0] mem_mask;

  int checks   = 0;
  int failures = 0;

  // Reference model state: 0 none, 1 IFU, 2 LSU
  bit m_live;
  bit m_busy;
  int m_owner;
  int m_age;
  bit m_favor_lsu;

  dmem_port_arbiter #(.WIDTH(W), .MASK_W(MW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
    .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_mask(lsu_mask), .lsu_gnt(lsu_gnt),
    .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_mask(mem_mask), .mem_ready(mem_ready),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_live = 0; m_busy = 0; m_owner = 0; m_age = 0; m_favor_lsu = 1;
  endfunction

  function automatic int model_winner();
    if (ifu_req && lsu_req) return m_favor_lsu ? 2 : 1;
    if (lsu_req) return 2;
    if (ifu_req) return 1;
    return 0;
  endfunction

  // Advance the model by one rising edge using the inputs present at that edge.
  function automatic void model_advance();
    int w;
    if (rst) begin
      model_reset();
    end else if (!m_live) begin
      m_live = 1;
    end else if (!m_busy) begin
      w = model_winner();
      if (w != 0 && mem_ready) begin
        m_busy = 1; m_owner = w; m_age = 0; m_favor_lsu = (w == 1);
      end
    end else if (mem_rvalid || m_age == TO - 1) begin
      m_busy = 0; m_owner = 0;
    end else begin
      m_age++;
    end
  endfunction

  function automatic logic [138:0] model_vec();
    logic ig, iv, lg, lv, mr, mwe, to_o;
    logic [W-1:0] ird, lrd, ma, mwd, rd;
    logic [MW-1:0] mm;
    int w;
    {ig, iv, lg, lv, mr, mwe, to_o} = '0;
    {ird, lrd, ma, mwd} = '0;
    mm = '0;
    if (m_busy) begin
      if (mem_rvalid || m_age == TO - 1) begin
        rd   = mem_rvalid ? mem_rdata : 32'h0;
        to_o = !mem_rvalid;
        if (m_owner == 1) begin iv = 1; ird = rd; end
        else begin lv = 1; lrd = rd; end
      end
    end else if (m_live) begin
      w = model_winner();
      if (w == 2) begin
        mr = 1; mwe = lsu_we; ma = lsu_addr; mwd = lsu_wdata; mm = lsu_mask;
        lg = mem_ready;
      end else if (w == 1) begin
        mr = 1; ma = ifu_addr;
        ig = mem_ready;
      end
    end
    return {ig, iv, ird, lg, lv, lrd, mr, mwe, ma, mwd, mm, to_o};
  endfunction

  function automatic logic [138:0] dut_vec();
    return {ifu_gnt, ifu_rvalid, ifu_rdata, lsu_gnt, lsu_rvalid, lsu_rdata,
            mem_req, mem_we, mem_addr, mem_wdata, mem_mask, timeout};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_advance();
    @(negedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    ifu_req = 0; lsu_req = 0; lsu_we = 0; mem_ready = 0; mem_rvalid = 0;
    ifu_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_mask = '0; mem_rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1; model_reset();
    quiet_inputs();
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; model_reset();
    quiet_inputs();
    ifu_req = 1; lsu_req = 1; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (dut_vec() !== 139'h0) begin
        failures++; $display("FAIL reset_outputs got=%h exp=0", dut_vec());
      end
      tick();
    end
    @(negedge clk); #1;
    rst = 0; mem_ready = 0; lsu_req = 0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++; $display("FAIL first_cycle_quiet got=%b exp=0", mem_req);
    end
    tick();
    checks++;
    if (mem_req !== 1'b1 || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL after_reset_req got=%h exp=%h", dut_vec(), model_vec());
    end
    ifu_req = 0; mem_rvalid = 0;
    tick();
  endtask

  task automatic test_ifu_read();
    ifu_req = 1; ifu_addr = 32'h8000_0000; mem_ready = 1;
    #1;
    checks++;
    if (ifu_gnt !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_we !== 1'b0 || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL ifu_grant got=%h exp=%h", dut_vec(), model_vec());
    end
    tick();
    ifu_req = 0;
    tick();
    mem_rvalid = 1; mem_rdata = 32'h0000_0013;
    #1;
    checks++;
    if (ifu_rvalid !== 1'b1 || ifu_rdata !== 32'h13 || lsu_rvalid !== 1'b0 || lsu_rdata !== '0) begin
      failures++; $display("FAIL ifu_resp rvalid=%b rdata=%h exp 1/00000013", ifu_rvalid, ifu_rdata);
    end
    tick();
    mem_rvalid = 0;
  endtask

  task automatic test_lsu_store();
    lsu_req = 1; lsu_we = 1; lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF;
    lsu_mask = 4'b0011; mem_ready = 1;
    #1;
    checks++;
    if (lsu_gnt !== 1'b1 || mem_we !== 1'b1 || mem_mask !== 4'b0011 ||
        mem_wdata !== 32'hDEAD_BEEF || mem_addr !== 32'h8000_1000) begin
      failures++; $display("FAIL lsu_store_req got=%h", dut_vec());
    end
    tick();
    lsu_req = 0;
    mem_rvalid = 1; mem_rdata = $urandom;
    #1;
    checks++;
    if (lsu_rvalid !== 1'b1 || ifu_rvalid !== 1'b0 || dut_vec() !== model_vec()) begin
      failures++; $display("FAIL lsu_store_ack got=%h exp=%h", dut_vec(), model_vec());
    end
    tick();
    mem_rvalid = 0;
  endtask

  task automatic test_round_robin();
    do_reset();
    ifu_req = 1; lsu_req = 1; mem_ready = 1; mem_rvalid = 1;
    ifu_addr = 32'h100; lsu_addr = 32'h200;
    for (int k = 0; k < 8; k++) begin
      mem_rdata = $urandom;
      #1;
      checks++;
      if (lsu_gnt !== (k % 4 == 0) || ifu_gnt !== (k % 4 == 2) || dut_vec() !== model_vec()) begin
        failures++;
        $display("FAIL rr_order k=%0d lsu_gnt=%b ifu_gnt=%b exp %b/%b", k, lsu_gnt, ifu_gnt, k % 4 == 0, k % 4 == 2);
      end
      tick();
    end
    quiet_inputs();
    tick();
  endtask

  task automatic test_ready_stall();
    logic [W-1:0] a0;
    lsu_req = 1; lsu_we = 0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_mask = 4'hA;
    mem_ready = 0;
    a0 = lsu_addr;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (mem_req !== 1'b1 || lsu_gnt !== 1'b0 || mem_addr !== a0 || dut_vec() !== model_vec()) begin
        failures++; $display("FAIL stall k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
      end
      tick();
    end
    mem_ready = 1;
    #1;
    checks++;
    if (lsu_gnt !== 1'b1 || mem_addr !== a0) begin
      failures++; $display("FAIL stall_grant got=%b exp=1", lsu_gnt);
    end
    tick();
    quiet_inputs();
    mem_rvalid = 1;
    tick();
    mem_rvalid = 0;
  endtask

  task automatic test_timeout();
    for (int r = 0; r < 2; r++) begin
      ifu_req = 1; ifu_addr = $urandom; mem_ready = 1;
      tick();
      ifu_req = 0;
      for (int b = 1; b <= TO; b++) begin
        mem_rdata = $urandom | 32'h1;
        mem_rvalid = (r == 1 && b == TO);
        #1;
        checks++;
        if (b < TO) begin
          if (timeout !== 1'b0 || ifu_rvalid !== 1'b0 || dut_vec() !== model_vec()) begin
            failures++; $display("FAIL wd_early r=%0d b=%0d got=%h", r, b, dut_vec());
          end
        end else if (r == 0) begin
          if (timeout !== 1'b1 || ifu_rvalid !== 1'b1 || ifu_rdata !== '0) begin
            failures++; $display("FAIL wd_abort to=%b rv=%b rd=%h exp 1/1/0", timeout, ifu_rvalid, ifu_rdata);
          end
        end else begin
          if (timeout !== 1'b0 || ifu_rvalid !== 1'b1 || ifu_rdata !== mem_rdata) begin
            failures++; $display("FAIL wd_rvalid_wins to=%b rv=%b rd=%h exp 0/1/%h", timeout, ifu_rvalid, ifu_rdata, mem_rdata);
          end
        end
        tick();
      end
      mem_rvalid = 0; mem_ready = 0; lsu_req = 1;
      #1;
      checks++;
      if (mem_req !== 1'b1) begin
        failures++; $display("FAIL wd_back_idle got=%b exp=1", mem_req);
      end
      lsu_req = 0;
      tick();
    end
  endtask

  task automatic test_reset_mid_busy();
    lsu_req = 1; lsu_we = 0; lsu_addr = $urandom; mem_ready = 1;
    tick();
    quiet_inputs();
    #2;
    rst = 1; model_reset();
    #1;
    checks++;
    if (dut_vec() !== 139'h0) begin
      failures++; $display("FAIL mid_busy_reset got=%h exp=0", dut_vec());
    end
    tick();
    rst = 0; mem_rvalid = 1; mem_rdata = $urandom;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++;
      if (lsu_rvalid !== 1'b0 || ifu_rvalid !== 1'b0 || dut_vec() !== model_vec()) begin
        failures++; $display("FAIL stale_resp k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
      end
      tick();
    end
    mem_rvalid = 0; lsu_req = 1; mem_ready = 0;
    #1;
    checks++;
    if (mem_req !== 1'b1) begin
      failures++; $display("FAIL post_reset_idle got=%b exp=1", mem_req);
    end
    quiet_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ifu_req    = ($urandom_range(0, 2) != 0);
      lsu_req    = ($urandom_range(0, 2) != 0);
      lsu_we     = $urandom;
      ifu_addr   = $urandom;
      lsu_addr   = $urandom;
      lsu_wdata  = $urandom;
      lsu_mask   = $urandom;
      mem_ready  = ($urandom_range(0, 3) != 0);
      mem_rvalid = ($urandom_range(0, 4) == 0);
      mem_rdata  = $urandom;
      #1;
      checks++;
      if (dut_vec() !== model_vec()) begin
        failures++; $display("FAIL random k=%0d got=%h exp=%h", k, dut_vec(), model_vec());
      end
      tick();
    end
    quiet_inputs();
    tick();
  endtask

  initial begin
    rst = 1;
    quiet_inputs();
    model_reset();
    @(negedge clk);
    test_reset();
    test_ifu_read();
    test_lsu_store();
    test_round_robin();
    test_ready_stall();
    test_timeout();
    test_reset_mid_busy();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
